equalizer_coeff_bank: RTL and testbench

- Coefficient responder for the equalizer's coefficient read port (`eq_coeff_addr` in, `eq_coeff` out).
- Holds two banks of biquad coefficients: an active bank serving the equalizer and a shadow bank written by the control side.
- A commit request swaps the banks only while the equalizer is between samples, so every sample uses one consistent coefficient set.
- After each swap the new active bank is copied into the shadow bank, so later partial updates start from the current set.

---
 rtl/equalizer_coeff_bank.sv | 227 ++++++++++++++++++++++
 tb/tb_equalizer_coeff_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/equalizer_coeff_bank.sv
`timescale 1ns/1ps
// equalizer_coeff_bank
//   Double-buffered biquad coefficient store for the equalizer read port.
//   The active bank serves eq_coeff_addr with one cycle of latency. The shadow
//   bank takes control-side writes. A commit swaps the banks while the
//   equalizer is between samples. The new active bank is then copied into the
//   shadow bank, so later partial updates start from the current set.
//   After reset both banks are filled with a passthrough set: unity at every
//   a0 and zero elsewhere.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   eq_coeff_addr   equalizer read address (per band: a0,a1,a2,b1,b2)
//   eq_coeff        registered active-bank word, 0 for out-of-range addresses
//   eq_idle         equalizer between samples; swap is allowed only then
//   wr_addr/data    shadow write address and data
//   wr_valid/ready  write handshake; ready only while IDLE
//   wr_err          one-cycle pulse after an accepted out-of-range write
//   commit          swap request pulse; ignored unless IDLE
//   commit_done     one-cycle pulse once the post-swap copy is complete
//   busy            high in any state other than IDLE
//   bank_sel        index of the active bank
module equalizer_coeff_bank #(
  parameter int  NR_CHANNELS    = 4,
  parameter int  NR_EQ_BANDS    = 8,
  parameter int  EQ_COEFF_WIDTH = 32,
  localparam int N              = NR_CHANNELS * NR_EQ_BANDS * 5,
  localparam int AW             = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic        [AW-1:0]             eq_coeff_addr,
  output logic signed [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                             eq_idle,
  input  logic        [AW-1:0]             wr_addr,
  input  logic signed [EQ_COEFF_WIDTH-1:0] wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic                             wr_err,
  input  logic                             commit,
  output logic                             commit_done,
  output logic                             busy,
  output logic                             bank_sel
);

  localparam int W = EQ_COEFF_WIDTH;
  localparam logic [AW:0] N_C    = (AW+1)'(N);
  localparam logic [AW:0] LAST_C = (AW+1)'(N - 1);
  // Three bits of gain headroom above the sign bit, so unity is 2^(W-4).
  localparam logic signed [W-1:0] UNITY_C = {4'b0001, {(W-4){1'b0}}};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_PEND, S_COPY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic     [AW:0]       r_cnt;
  logic     [AW:0]       w_cnt_nxt;
  logic     [2:0]        r_ph;
  logic     [2:0]        w_ph_nxt;
  logic                  r_bank_sel;
  logic                  r_wr_err;
  logic                  r_commit_done;
  logic                  w_done_nxt;
  logic                  w_swap;
  logic                  w_cp_rd;
  logic                  w_wr_ready;
  logic                  w_wr_acc;
  logic                  w_wr_inr;
  logic                  w_rd_inr;

  logic signed [W-1:0]   r_bank0 [N];
  logic signed [W-1:0]   r_bank1 [N];

  // Copy pipeline: read the active bank at p0, write the shadow bank at p1.
  logic                  r_cp_vld_p1;
  logic     [AW-1:0]     r_cp_addr_p1;
  logic signed [W-1:0]   r_cp_data_p1;

  logic                  w_we0;
  logic                  w_we1;
  logic     [AW-1:0]     w_wa;
  logic signed [W-1:0]   w_wd;
  logic signed [W-1:0]   w_rd_word;
  logic signed [W-1:0]   r_eq_coeff;

  assign w_wr_acc = wr_valid & w_wr_ready;
  assign w_wr_inr = ({1'b0, wr_addr} < N_C);
  assign w_rd_inr = ({1'b0, eq_coeff_addr} < N_C);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ph_nxt    = r_ph;
    w_wr_ready  = 1'b0;
    w_swap      = 1'b0;
    w_cp_rd     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_ph_nxt  = (r_ph == 3'd4) ? 3'd0 : r_ph + 3'd1;
        if (r_cnt == LAST_C) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_ph_nxt    = '0;
        end
      end
      S_IDLE: begin
        w_wr_ready = 1'b1;
        if (commit) begin
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (eq_idle) begin
          w_swap      = 1'b1;
          w_state_nxt = S_COPY;
          w_cnt_nxt   = '0;
        end
      end
      S_COPY: begin
        // The counter reaches N in the cycle where the last p1 write lands.
        if (r_cnt == N_C) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cp_rd   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_ph          <= '0;
      r_bank_sel    <= 1'b0;
      r_wr_err      <= 1'b0;
      r_commit_done <= 1'b0;
      r_cp_vld_p1   <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_ph          <= w_ph_nxt;
      r_bank_sel    <= r_bank_sel ^ w_swap;
      r_wr_err      <= w_wr_acc & ~w_wr_inr;
      r_commit_done <= w_done_nxt;
      r_cp_vld_p1   <= w_cp_rd;
    end
  end

  // Bank write select. The sources are mutually exclusive by state:
  // INIT fills both banks, IDLE writes the shadow bank, and the COPY pipeline
  // writes the shadow bank.
  always_comb begin
    w_we0 = 1'b0;
    w_we1 = 1'b0;
    w_wa  = '0;
    w_wd  = '0;
    if (r_state == S_INIT) begin
      w_we0 = 1'b1;
      w_we1 = 1'b1;
      w_wa  = r_cnt[AW-1:0];
      w_wd  = (r_ph == 3'd0) ? UNITY_C : '0;
    end else if (w_wr_acc && w_wr_inr) begin
      w_we0 = r_bank_sel;
      w_we1 = ~r_bank_sel;
      w_wa  = wr_addr;
      w_wd  = wr_data;
    end else if (r_cp_vld_p1) begin
      w_we0 = r_bank_sel;
      w_we1 = ~r_bank_sel;
      w_wa  = r_cp_addr_p1;
      w_wd  = r_cp_data_p1;
    end
  end

  // Stage p0 -> p1: memory writes and copy read
  always_ff @(posedge clk) begin
    if (w_we0) begin
      r_bank0[w_wa] <= w_wd;
    end
    if (w_we1) begin
      r_bank1[w_wa] <= w_wd;
    end
    if (w_cp_rd) begin
      r_cp_addr_p1 <= r_cnt[AW-1:0];
      r_cp_data_p1 <= r_bank_sel ? r_bank1[r_cnt[AW-1:0]] : r_bank0[r_cnt[AW-1:0]];
    end
  end

  // Equalizer read port
  always_comb begin
    w_rd_word = '0;
    if (w_rd_inr) begin
      w_rd_word = r_bank_sel ? r_bank1[eq_coeff_addr] : r_bank0[eq_coeff_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eq_coeff <= '0;
    end else begin
      r_eq_coeff <= w_rd_word;
    end
  end

  assign eq_coeff    = r_eq_coeff;
  assign wr_ready    = w_wr_ready;
  assign wr_err      = r_wr_err;
  assign commit_done = r_commit_done;
  assign busy        = (r_state != S_IDLE);
  assign bank_sel    = r_bank_sel;

endmodule

// File: tb/tb_equalizer_coeff_bank.sv
`timescale 1ns/1ps
module tb_equalizer_coeff_bank;

  localparam int N  = 160;
  localparam int AW = 8;
  localparam int W  = 32;

  localparam logic [31:0] UNITY = 32'h1000_0000;
  localparam logic [31:0] D7    = 32'h0ABC_DEF0;
  localparam logic [31:0] D3    = 32'h1234_5678;

  localparam int SIG_COEFF = 0;
  localparam int SIG_BUSY  = 1;
  localparam int SIG_WRDY  = 2;
  localparam int SIG_WERR  = 3;
  localparam int SIG_DONE  = 4;
  localparam int SIG_BSEL  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] eq_coeff_addr = '0;
  logic [W-1:0]  eq_coeff;
  logic          eq_idle = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_err;
  logic          commit = 1'b0;
  logic          commit_done;
  logic          busy;
  logic          bank_sel;

  equalizer_coeff_bank #(
    .NR_CHANNELS    (4),
    .NR_EQ_BANDS    (8),
    .EQ_COEFF_WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .eq_idle       (eq_idle),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_err        (wr_err),
    .commit        (commit),
    .commit_done   (commit_done),
    .busy          (busy),
    .bank_sel      (bank_sel)
  );

  always #5 clk = ~clk;

  // Scoreboard: each entry names an output, its required value and the
  // cycle whose falling edge it must be observed on.
  typedef struct {
    int          sig;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act_of(input int s);
    case (s)
      SIG_COEFF: return eq_coeff;
      SIG_BUSY:  return {31'b0, busy};
      SIG_WRDY:  return {31'b0, wr_ready};
      SIG_WERR:  return {31'b0, wr_err};
      SIG_DONE:  return {31'b0, commit_done};
      SIG_BSEL:  return {31'b0, bank_sel};
      default:   return 32'hDEAD_0000;
    endcase
  endfunction

  // Monitor: compares every entry that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        logic [31:0] a;
        a = act_of(q[i].sig);
        n_tests++;
        if (q[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", q[i].name, q[i].due, cyc);
        end else if (a !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", q[i].name, a, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [31:0] e, input int lat, input string nm);
    exp_t t;
    t.sig  = s;
    t.exp  = e;
    t.due  = cyc + lat;
    t.name = nm;
    q.push_back(t);
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
    eq_coeff_addr = a;
    push(SIG_COEFF, e, 1, nm);
    tick(2);
  endtask

  task automatic after_init(input string tag);
    tick(N - 1);
    push(SIG_BUSY, 32'd1, 0, {tag, "_busy_last_init"});
    push(SIG_WRDY, 32'd0, 0, {tag, "_wrdy_last_init"});
    tick(1);
    push(SIG_BUSY, 32'd0, 0, {tag, "_busy_idle"});
    push(SIG_WRDY, 32'd1, 0, {tag, "_wrdy_idle"});
    push(SIG_BSEL, 32'd0, 0, {tag, "_bsel_idle"});
  endtask

  // Called k cycles after the swap edge; runs to the end of the copy.
  task automatic finish_copy(input int k, input string tag);
    tick(N - k);
    push(SIG_DONE, 32'd0, 0, {tag, "_done_early"});
    push(SIG_BUSY, 32'd1, 0, {tag, "_busy_copy"});
    tick(1);
    push(SIG_DONE, 32'd1, 0, {tag, "_done_pulse"});
    push(SIG_BUSY, 32'd0, 0, {tag, "_busy_after"});
    push(SIG_WRDY, 32'd1, 0, {tag, "_wrdy_after"});
    tick(1);
    push(SIG_DONE, 32'd0, 0, {tag, "_done_end"});
  endtask

  task automatic commit_swap(input logic exp_sel, input string tag);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    push(SIG_BUSY, 32'd1, 0, {tag, "_busy_pend"});
    push(SIG_WRDY, 32'd0, 0, {tag, "_wrdy_pend"});
    push(SIG_BSEL, {31'b0, ~exp_sel}, 0, {tag, "_bsel_pre"});
    tick(1);
    push(SIG_BSEL, {31'b0, exp_sel}, 0, {tag, "_bsel_swapped"});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    tick(1);
    push(SIG_COEFF, 32'd0, 0, "rst_coeff");
    push(SIG_BUSY,  32'd1, 0, "rst_busy");
    push(SIG_WRDY,  32'd0, 0, "rst_wrdy");
    push(SIG_WERR,  32'd0, 0, "rst_werr");
    push(SIG_DONE,  32'd0, 0, "rst_done");
    push(SIG_BSEL,  32'd0, 0, "rst_bsel");
    tick(1);
    rst_n = 1'b1;
    after_init("init");
    eq_idle = 1'b1;

    // Passthrough pattern
    read_chk(8'd0,   UNITY, "init_a0_0");
    read_chk(8'd5,   UNITY, "init_a0_5");
    read_chk(8'd155, UNITY, "init_a0_155");
    read_chk(8'd1,   32'd0, "init_a1_1");
    read_chk(8'd4,   32'd0, "init_b2_4");
    read_chk(8'd159, 32'd0, "init_b2_159");
    read_chk(8'd200, 32'd0, "oob_read_200");

    // Shadow write leaves the active bank untouched
    wr_addr = 8'd7; wr_data = D7; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    push(SIG_WERR, 32'd0, 0, "wr7_no_err");
    read_chk(8'd7, 32'd0, "wr7_active_untouched");

    // First commit: new word visible one cycle after the swap
    commit_swap(1'b1, "c1");
    push(SIG_COEFF, 32'd0, 0, "c1_coeff_old");
    push(SIG_COEFF, D7, 1, "c1_coeff_new");
    finish_copy(0, "c1");

    // Second commit: copy carried addr 7 into the other bank
    commit_swap(1'b0, "c2");
    read_chk(8'd7, D7, "c2_copied_7");
    read_chk(8'd0, UNITY, "c2_copied_0");
    finish_copy(4, "c2");

    // Commit held off by eq_idle=0 for 50 cycles; a repeat commit is dropped
    eq_idle = 1'b0;
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(25);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(24);
    push(SIG_BSEL, 32'd0, 0, "hold_bsel");
    push(SIG_BUSY, 32'd1, 0, "hold_busy");
    push(SIG_WRDY, 32'd0, 0, "hold_wrdy");
    eq_idle = 1'b1;
    tick(1);
    push(SIG_BSEL, 32'd1, 0, "hold_swap");
    finish_copy(0, "c3");
    push(SIG_BSEL, 32'd1, 0, "c3_single_toggle");
    tick(2);
    push(SIG_BUSY, 32'd0, 0, "c3_no_latched_commit");

    // Out-of-range write
    wr_addr = 8'd160; wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    push(SIG_WERR, 32'd1, 0, "oob_wr_err");
    tick(1);
    push(SIG_WERR, 32'd0, 0, "oob_wr_err_end");
    read_chk(8'd160, 32'd0, "oob_wr_read_160");
    read_chk(8'd0, UNITY, "oob_wr_bank_intact");

    // Write and commit in the same cycle; commit during COPY ignored
    wr_addr = 8'd3; wr_data = D3; wr_valid = 1'b1;
    commit_swap(1'b0, "c4");
    read_chk(8'd3, D3, "c4_same_cycle_write");
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    finish_copy(3, "c4");
    tick(2);
    push(SIG_BUSY, 32'd0, 0, "c4_copy_commit_dropped");
    push(SIG_BSEL, 32'd0, 0, "c4_single_toggle");

    // Reset in the middle of COPY
    wr_valid = 1'b0;
    commit_swap(1'b1, "c5");
    read_chk(8'd7, D7, "c5_coeff_before_rst");
    tick(18);
    rst_n = 1'b0;
    #1;
    push(SIG_COEFF, 32'd0, 0, "mid_rst_coeff");
    push(SIG_BUSY,  32'd1, 0, "mid_rst_busy");
    push(SIG_WRDY,  32'd0, 0, "mid_rst_wrdy");
    push(SIG_BSEL,  32'd0, 0, "mid_rst_bsel");
    push(SIG_DONE,  32'd0, 0, "mid_rst_done");
    tick(2);
    rst_n = 1'b1;
    after_init("reinit");
    read_chk(8'd7,   32'd0, "reinit_7_cleared");
    read_chk(8'd3,   32'd0, "reinit_3_cleared");
    read_chk(8'd0,   UNITY, "reinit_a0_0");
    read_chk(8'd155, UNITY, "reinit_a0_155");
    commit_swap(1'b1, "c6");
    read_chk(8'd7,   32'd0, "reinit_shadow_7_cleared");
    finish_copy(2, "c6");

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
